// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised modulo-N up/down counter with wrap/saturate modes and cascade flags
module mod_updown_counter #(
  parameter int          WIDTH       = 4,
  parameter int unsigned MAX_COUNT   = 15,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             at_limit
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VALUE);
  logic             end_hit;
  logic [WIDTH-1:0] lv;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_d;
  logic             at_limit_d;
  // next state: clr beats load beats en; an end of range either wraps or holds
  always_comb begin
    lv = load_value > MAX ? MAX : load_value;
    end_hit = up_dn ? count == MAX : count == '0;
    step = end_hit ? (SATURATE ? count : (up_dn ? '0 : MAX)) : (up_dn ? count + 1'b1 : count - 1'b1);
    count_d = clr ? '0 : load ? lv : en ? step : count;
    wrapped_d = !clr && !load && en && end_hit && !SATURATE;
    at_limit_d = clr ? 1'b0 : load ? SATURATE && (lv == MAX || lv == '0) : en ? SATURATE && end_hit : at_limit;
  end
  assign tc = en && end_hit;
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RST;
      wrapped <= 1'b0;
      at_limit <= 1'b0;
    end else begin
      count <= count_d;
      wrapped <= wrapped_d;
      at_limit <= at_limit_d;
    end
  end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed checks of wrap, saturate, load/clear priority, async reset and cascading
module tb_mod_updown_counter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic a_en = 0, a_clr = 0, a_load = 0, a_up = 1;
  logic [3:0] a_lv = '0;
  logic [3:0] a_count;
  logic a_tc, a_wr, a_al;
  logic s_en = 0, s_clr = 0, s_load = 0, s_up = 1;
  logic [3:0] s_lv = '0;
  logic [3:0] s_count;
  logic s_tc, s_wr, s_al;
  logic c_en = 0;
  logic [3:0] u_count, t_count;
  logic u_tc, u_wr, u_al, t_tc, t_wr, t_al;
  int pulses = 0;
  int pulse_at = 0;
  logic [3:0] exp2 [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
  logic       wr2  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VALUE(0)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .clr(a_clr), .load(a_load), .load_value(a_lv), .up_dn(a_up),
    .count(a_count), .tc(a_tc), .wrapped(a_wr), .at_limit(a_al));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1), .RESET_VALUE(0)) dut_s (
    .clk(clk), .reset(reset), .en(s_en), .clr(s_clr), .load(s_load), .load_value(s_lv), .up_dn(s_up),
    .count(s_count), .tc(s_tc), .wrapped(s_wr), .at_limit(s_al));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VALUE(0)) dut_u (
    .clk(clk), .reset(reset), .en(c_en), .clr(1'b0), .load(1'b0), .load_value(4'd0), .up_dn(1'b1),
    .count(u_count), .tc(u_tc), .wrapped(u_wr), .at_limit(u_al));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0), .RESET_VALUE(0)) dut_t (
    .clk(clk), .reset(reset), .en(u_tc), .clr(1'b0), .load(1'b0), .load_value(4'd0), .up_dn(1'b1),
    .count(t_count), .tc(t_tc), .wrapped(t_wr), .at_limit(t_al));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_count", a_count, 0);
    chk("rst_wrapped", a_wr, 0);
    chk("rst_at_limit", a_al, 0);
    #10;
    chk("rst_hold", a_count, 0);
    reset = 1'b1;
    a_en = 1'b1;
    a_up = 1'b1;
    #1;
    chk("up_tc0", a_tc, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("up_count%0d", i), a_count, i % 10);
      chk($sformatf("up_wr%0d", i), a_wr, i == 10);
      chk($sformatf("up_tc%0d", i), a_tc, i == 9);
      chk($sformatf("up_al%0d", i), a_al, 0);
    end
    a_load = 1'b1;
    a_lv = 4'd2;
    tick();
    chk("ld2_count", a_count, 2);
    a_load = 1'b0;
    a_up = 1'b0;
    #1;
    chk("dn_tc2", a_tc, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("dn_count%0d", i), a_count, exp2[i]);
      chk($sformatf("dn_wr%0d", i), a_wr, wr2[i]);
      chk($sformatf("dn_tc%0d", i), a_tc, exp2[i] == 4'd0);
    end
    a_en = 1'b0;
    #1;
    chk("tc_needs_en", a_tc, 0);
    tick();
    chk("hold_count", a_count, 8);
    chk("hold_wr", a_wr, 0);
    s_load = 1'b1;
    s_lv = 4'd7;
    tick();
    chk("sat_ld7", s_count, 7);
    chk("sat_ld7_al", s_al, 0);
    s_load = 1'b0;
    s_en = 1'b1;
    s_up = 1'b1;
    tick();
    chk("sat_8", s_count, 8);
    chk("sat_8_al", s_al, 0);
    tick();
    chk("sat_9", s_count, 9);
    chk("sat_9_al", s_al, 0);
    chk("sat_9_tc", s_tc, 1);
    tick();
    chk("sat_9h", s_count, 9);
    chk("sat_9h_al", s_al, 1);
    chk("sat_9h_wr", s_wr, 0);
    tick();
    chk("sat_9h2", s_count, 9);
    chk("sat_9h2_al", s_al, 1);
    s_up = 1'b0;
    tick();
    chk("sat_dn8", s_count, 8);
    chk("sat_dn8_al", s_al, 0);
    s_en = 1'b0;
    s_load = 1'b1;
    s_lv = 4'd0;
    tick();
    chk("sat_ld0", s_count, 0);
    chk("sat_ld0_al", s_al, 1);
    s_load = 1'b0;
    s_en = 1'b1;
    tick();
    chk("sat_lo_hold", s_count, 0);
    chk("sat_lo_al", s_al, 1);
    chk("sat_lo_wr", s_wr, 0);
    s_en = 1'b0;
    a_up = 1'b1;
    a_load = 1'b1;
    a_lv = 4'd12;
    tick();
    chk("ld12_clamp", a_count, 9);
    chk("ld12_wr", a_wr, 0);
    a_clr = 1'b1;
    a_en = 1'b1;
    tick();
    chk("clr_wins", a_count, 0);
    chk("clr_wr", a_wr, 0);
    a_clr = 1'b0;
    a_lv = 4'd4;
    a_en = 1'b1;
    tick();
    chk("ld_ignores_en", a_count, 4);
    a_load = 1'b0;
    tick();
    chk("pre_rst5", a_count, 5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst", a_count, 0);
    chk("async_rst_wr", a_wr, 0);
    tick();
    chk("rst_held", a_count, 0);
    #2;
    reset = 1'b1;
    tick();
    chk("rst_resume", a_count, 1);
    c_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (t_wr) begin
        pulses++;
        pulse_at = i;
      end
      if (i == 37) begin
        chk("casc37_units", u_count, 7);
        chk("casc37_tens", t_count, 3);
      end
    end
    chk("casc_units", u_count, 0);
    chk("casc_tens", t_count, 0);
    chk("casc_pulses", pulses, 1);
    chk("casc_pulse_at", pulse_at, 100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
